// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bus bundle between the MA stage (master) and the data-memory responder
// (slave).
//   Dmem_Waddr/Dmem_Wdata/Dmem_Wen : write port, committed at the rising edge
//   Dmem_Raddr/Dmem_Ren            : read port
//   Dmem_Rdata                     : same-cycle read data (0 when not serviced)
//   Dmem_Ready                     : memory is out of its clear sweep
//   Dmem_Err                       : sticky, access attempted while not ready
//   Dmem_Wr_Cnt/Dmem_Rd_Cnt        : saturating access counters
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DATA_WIDTH = 32
);
  logic [MEM_ADDR_WIDTH-1:0] Dmem_Waddr;
  logic [MEM_DATA_WIDTH-1:0] Dmem_Wdata;
  logic                      Dmem_Wen;
  logic [MEM_ADDR_WIDTH-1:0] Dmem_Raddr;
  logic                      Dmem_Ren;
  logic [MEM_DATA_WIDTH-1:0] Dmem_Rdata;
  logic                      Dmem_Ready;
  logic                      Dmem_Err;
  logic [15:0]               Dmem_Wr_Cnt;
  logic [15:0]               Dmem_Rd_Cnt;

  modport master (
    output Dmem_Waddr, Dmem_Wdata, Dmem_Wen, Dmem_Raddr, Dmem_Ren,
    input  Dmem_Rdata, Dmem_Ready, Dmem_Err, Dmem_Wr_Cnt, Dmem_Rd_Cnt
  );

  modport slave (
    input  Dmem_Waddr, Dmem_Wdata, Dmem_Wen, Dmem_Raddr, Dmem_Ren,
    output Dmem_Rdata, Dmem_Ready, Dmem_Err, Dmem_Wr_Cnt, Dmem_Rd_Cnt
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data memory for the MA stage. After reset the array is swept to zero one
// word per cycle (CLEAR); afterwards (READY) it services one read and one
// write per cycle. Reads are combinational so the MA stage can capture load
// data in the same cycle it issues the request.
// Ports:
//   Clk  : clock, all state on the rising edge
//   Rst  : asynchronous active-low reset
//   bus  : dmem_responder_if.slave (read/write ports, status, counters)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                    r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_clr_ptr;
  logic                      r_ready;
  logic                      r_err;
  logic [15:0]               r_wr_cnt;
  logic [15:0]               r_rd_cnt;
  logic [MEM_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic w_in_ready;
  logic w_wr_commit;
  logic w_rd_service;
  logic w_clr_we;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_in_ready   = (r_state == READY);
  assign w_wr_commit  = w_in_ready && bus.Dmem_Wen;
  assign w_rd_service = w_in_ready && bus.Dmem_Ren;
  // Rst gates the sweep write so the array is untouched while reset is held.
  assign w_clr_we     = Rst && (r_state == CLEAR);

  // Control FSM with registered status outputs and counters.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (bus.Dmem_Wen || bus.Dmem_Ren) r_err <= 1'b1;
          if (r_clr_ptr == LAST_ADDR) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          if (bus.Dmem_Wen) r_wr_cnt <= sat_inc(r_wr_cnt);
          if (bus.Dmem_Ren) r_rd_cnt <= sat_inc(r_rd_cnt);
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Storage: not reset; the sweep provides the zero initial contents.
  always_ff @(posedge Clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_commit) begin
      r_mem[bus.Dmem_Waddr] <= bus.Dmem_Wdata;
    end
  end

  // Asynchronous read returns pre-write contents on a same-address collision.
  assign bus.Dmem_Rdata  = w_rd_service ? r_mem[bus.Dmem_Raddr] : '0;
  assign bus.Dmem_Ready  = r_ready;
  assign bus.Dmem_Err    = r_err;
  assign bus.Dmem_Wr_Cnt = r_wr_cnt;
  assign bus.Dmem_Rd_Cnt = r_rd_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic Clk;
  logic Rst;

  dmem_responder_if #(.MEM_ADDR_WIDTH(12), .MEM_DATA_WIDTH(32)) bus ();

  dmem_responder #(.MEM_ADDR_WIDTH(12), .MEM_DATA_WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard and reference model
  logic [31:0] exp_q [$];
  logic [31:0] mdl [int];
  logic [15:0] exp_wr = 16'd0;
  logic [15:0] exp_rd = 16'd0;

  function automatic logic [31:0] mdl_get(input int a);
    return mdl.exists(a) ? mdl[a] : 32'd0;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] v, input int n);
    int s;
    s = int'(v) + n;
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    bus.Dmem_Waddr = a[11:0];
    bus.Dmem_Wdata = d;
    bus.Dmem_Wen   = 1'b1;
    @(negedge Clk);
    bus.Dmem_Wen = 1'b0;
    mdl[a] = d;
    exp_wr = sat_add(exp_wr, 1);
  endtask

  task automatic do_read(input string tag, input int a);
    exp_q.push_back(mdl_get(a));
    bus.Dmem_Raddr = a[11:0];
    bus.Dmem_Ren   = 1'b1;
    #1;
    chk(tag, bus.Dmem_Rdata, exp_q.pop_front());
    @(negedge Clk);
    bus.Dmem_Ren = 1'b0;
    exp_rd = sat_add(exp_rd, 1);
  endtask

  // Counts rising edges after reset release until Ready is seen high.
  task automatic sweep(input bit inject, output int cyc);
    cyc = 0;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (inject && cyc == 9) begin
        bus.Dmem_Waddr = 12'h005;
        bus.Dmem_Wdata = 32'hFFFFFFFF;
        bus.Dmem_Wen   = 1'b1;
      end
      if (inject && cyc == 10) bus.Dmem_Wen = 1'b0;
      if (bus.Dmem_Ready || cyc >= 5000) break;
    end
    @(negedge Clk);
  endtask

  initial begin
    int cyc;
    Rst = 1'b1;
    bus.Dmem_Waddr = '0;
    bus.Dmem_Wdata = '0;
    bus.Dmem_Wen   = 1'b0;
    bus.Dmem_Raddr = '0;
    bus.Dmem_Ren   = 1'b0;
    #2 Rst = 1'b0;
    bus.Dmem_Ren = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_ready", {31'd0, bus.Dmem_Ready}, 32'd0);
    chk("rst_err",   {31'd0, bus.Dmem_Err},   32'd0);
    chk("rst_wrcnt", {16'd0, bus.Dmem_Wr_Cnt}, 32'd0);
    chk("rst_rdcnt", {16'd0, bus.Dmem_Rd_Cnt}, 32'd0);
    chk("rst_rdata", bus.Dmem_Rdata, 32'd0);
    bus.Dmem_Ren = 1'b0;
    @(negedge Clk);

    // First sweep, with an illegal write at cycle 10
    Rst = 1'b1;
    sweep(1'b1, cyc);
    chk("sweep1_cycles", cyc, 32'd4096);
    chk("err_set", {31'd0, bus.Dmem_Err}, 32'd1);
    chk("cnt_after_sweep", {bus.Dmem_Wr_Cnt, bus.Dmem_Rd_Cnt}, 32'd0);
    do_read("rd_0x000", 12'h000);
    do_read("rd_0x7ff", 12'h7FF);
    do_read("rd_0xfff", 12'hFFF);
    do_read("rd_0x005_after_clear_write", 12'h005);
    chk("err_sticky", {31'd0, bus.Dmem_Err}, 32'd1);

    // Write then read
    do_write(12'h010, 32'hDEADBEEF);
    bus.Dmem_Raddr = 12'h010;
    #1;
    chk("rdata_ren0", bus.Dmem_Rdata, 32'd0);
    do_read("rd_0x010", 12'h010);
    chk("wr_cnt_1", {16'd0, bus.Dmem_Wr_Cnt}, {16'd0, exp_wr});
    chk("rd_cnt_1", {16'd0, bus.Dmem_Rd_Cnt}, {16'd0, exp_rd});

    // Same-address collision: old data this cycle, new data next cycle
    do_write(12'h020, 32'h11111111);
    exp_q.push_back(mdl_get(12'h020));
    bus.Dmem_Waddr = 12'h020;
    bus.Dmem_Wdata = 32'h22222222;
    bus.Dmem_Wen   = 1'b1;
    bus.Dmem_Raddr = 12'h020;
    bus.Dmem_Ren   = 1'b1;
    #1;
    chk("collide_old", bus.Dmem_Rdata, exp_q.pop_front());
    @(negedge Clk);
    bus.Dmem_Wen = 1'b0;
    bus.Dmem_Ren = 1'b0;
    mdl[12'h020] = 32'h22222222;
    exp_wr = sat_add(exp_wr, 1);
    exp_rd = sat_add(exp_rd, 1);
    chk("both_cnt_wr", {16'd0, bus.Dmem_Wr_Cnt}, {16'd0, exp_wr});
    chk("both_cnt_rd", {16'd0, bus.Dmem_Rd_Cnt}, {16'd0, exp_rd});
    do_read("collide_new", 12'h020);

    // Different addresses in the same cycle
    exp_q.push_back(mdl_get(12'h010));
    bus.Dmem_Waddr = 12'h030;
    bus.Dmem_Wdata = 32'h0BADF00D;
    bus.Dmem_Wen   = 1'b1;
    bus.Dmem_Raddr = 12'h010;
    bus.Dmem_Ren   = 1'b1;
    #1;
    chk("diff_addr_rd", bus.Dmem_Rdata, exp_q.pop_front());
    @(negedge Clk);
    bus.Dmem_Wen = 1'b0;
    bus.Dmem_Ren = 1'b0;
    mdl[12'h030] = 32'h0BADF00D;
    exp_wr = sat_add(exp_wr, 1);
    exp_rd = sat_add(exp_rd, 1);
    do_read("diff_addr_wr", 12'h030);
    do_read("rd_0xfff_untouched", 12'hFFF);

    // Reset mid-operation
    do_write(12'h100, 32'hA5A5A5A5);
    do_read("rd_0x100_before_rst", 12'h100);
    Rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.Dmem_Ready}, 32'd0);
    chk("midrst_cnts", {bus.Dmem_Wr_Cnt, bus.Dmem_Rd_Cnt}, 32'd0);
    chk("midrst_err", {31'd0, bus.Dmem_Err}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    mdl.delete();
    exp_wr = 16'd0;
    exp_rd = 16'd0;
    sweep(1'b0, cyc);
    chk("sweep2_cycles", cyc, 32'd4096);
    do_read("rd_0x100_after_rst", 12'h100);
    do_read("rd_0x010_after_rst", 12'h010);
    chk("err_clean", {31'd0, bus.Dmem_Err}, 32'd0);

    // Read counter saturation
    bus.Dmem_Raddr = 12'h200;
    bus.Dmem_Ren   = 1'b1;
    repeat (65540) @(negedge Clk);
    bus.Dmem_Ren = 1'b0;
    exp_rd = sat_add(exp_rd, 65540);
    #1;
    chk("rd_cnt_sat", {16'd0, bus.Dmem_Rd_Cnt}, {16'd0, exp_rd});
    chk("wr_cnt_hold", {16'd0, bus.Dmem_Wr_Cnt}, {16'd0, exp_wr});
    @(negedge Clk);
    chk("rd_cnt_sat_hold", {16'd0, bus.Dmem_Rd_Cnt}, 32'h0000FFFF);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 12, word address width; depth is 2**MEM_ADDR_WIDTH words.
REQ-002 Parameter MEM_DATA_WIDTH, default 32, word width in bits.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  asynchronous, active-low reset.
REQ-005 Dmem_Waddr  input  MEM_ADDR_WIDTH  write word address from the MA stage.
REQ-006 Dmem_Wdata  input  MEM_DATA_WIDTH  write data.
REQ-007 Dmem_Wen  input  1  write enable, sampled at the rising edge.
REQ-008 Dmem_Raddr  input  MEM_ADDR_WIDTH  read word address.
REQ-009 Dmem_Ren  input  1  read enable.
REQ-010 Dmem_Rdata  output  MEM_DATA_WIDTH  read data, valid in the same cycle as Dmem_Ren.
REQ-011 Dmem_Ready  output  1  high when accesses are serviced; low during the clear sweep.
REQ-012 Dmem_Err  output  1  sticky flag: an access was attempted while not ready.
REQ-013 Dmem_Wr_Cnt  output  16  saturating count of committed writes.
REQ-014 Dmem_Rd_Cnt  output  16  saturating count of serviced reads.

Function
REQ-015 Storage: array of 2**MEM_ADDR_WIDTH words of MEM_DATA_WIDTH bits; the array itself is not reset.
REQ-016 FSM states: CLEAR, READY; the reset state is CLEAR.
REQ-017 CLEAR behaviour: each cycle write 0 to array[clr_ptr], then increment clr_ptr.
REQ-018 Transition CLEAR->READY: on the cycle that clears the last address (2**MEM_ADDR_WIDTH-1).
REQ-019 Clear timing: the full sweep takes exactly 2**MEM_ADDR_WIDTH cycles (4096 at default).
REQ-020 READY is terminal until the next Rst assertion.
REQ-021 Dmem_Ready = 1 only in READY; it is a registered output.
REQ-022 Read path, READY with Dmem_Ren=1: Dmem_Rdata = array[Dmem_Raddr] combinationally (zero-cycle latency); this matches the MA stage, which captures load data in the same cycle.
REQ-023 Read path, Dmem_Ren=0 or state CLEAR: Dmem_Rdata = 0.
REQ-024 Write path: in READY with Dmem_Wen=1, array[Dmem_Waddr] <= Dmem_Wdata at the rising edge.
REQ-025 Write path during CLEAR: Dmem_Wen is ignored and the array keeps its clear value.
REQ-026 Simultaneous read and write to the same address in one cycle: Dmem_Rdata returns the old (pre-write) contents; the new value is visible from the next cycle.
REQ-027 Simultaneous read and write to different addresses: both are serviced independently in the same cycle.
REQ-028 Dmem_Err is set (sticky) on any cycle in CLEAR where Dmem_Wen=1 or Dmem_Ren=1; it is cleared only by Rst.
REQ-029 Dmem_Wr_Cnt increments by 1 per write committed in READY and saturates at 16'hFFFF (no wrap).
REQ-030 Dmem_Rd_Cnt increments by 1 per cycle with Dmem_Ren=1 in READY and saturates at 16'hFFFF.
REQ-031 Both counters can increment in the same cycle.
REQ-032 Address inputs are full-width, so no out-of-range case exists; Dmem_Waddr and Dmem_Raddr wrap naturally.

Reset
REQ-033 Rst=0 immediately (asynchronously) forces: state=CLEAR, clr_ptr=0, Dmem_Ready=0, Dmem_Err=0, Dmem_Wr_Cnt=0, Dmem_Rd_Cnt=0, Dmem_Rdata=0.
REQ-034 Rst asserted mid-sweep or in READY restarts the full clear from address 0 after release.
REQ-035 No array writes occur while Rst=0.

Verification
REQ-036 Clear sweep: release Rst, no traffic -> Dmem_Ready rises exactly 4096 cycles later; reading any of addresses 0, 0x7FF, 0xFFF returns 0.
REQ-037 Write then read: in READY, write 0xDEADBEEF to 0x010, then Ren with Raddr=0x010 next cycle -> Dmem_Rdata=0xDEADBEEF in that cycle; Wr_Cnt=1, Rd_Cnt=1.
REQ-038 Same-address collision: array[0x020]=0x11111111; same cycle Wen Wdata=0x22222222 and Ren at 0x020 -> Rdata=0x11111111; next-cycle read -> 0x22222222.
REQ-039 Access during CLEAR: Wen=1 at addr 0x005 with data 0xFFFFFFFF at cycle 10 after release -> Dmem_Err=1 and stays 1; after READY, a read of 0x005 returns 0.
REQ-040 Reset mid-operation: write 0xA5A5A5A5 to 0x100, pulse Rst low for 1 cycle -> Ready=0 and counters=0 immediately; after 4096 cycles a read of 0x100 returns 0.
REQ-041 Counter saturation: 65540 consecutive reads in READY -> Dmem_Rd_Cnt holds 0xFFFF.
